// File: rtl/uart_rx_multi.sv
// uart_rx_multi: parametrised UART receiver with 3-sample majority voting, line arming,
// start-glitch rejection and a valid/ready holding register that reports overruns.
module uart_rx_multi #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(2 * CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 5);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_SMP0 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_DEC  = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_DATA = BW'(DATA_BITS);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS + (PARITY_MODE != 0 ? 1 : 0) + STOP_BITS);

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s, rx_d;
    logic                 s0, s1, maj, dec, wrap, done, par, ferr, fe_now;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;

    assign busy = (state != ARM) && (state != IDLE);

    always_comb begin
        maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        dec     = cnt == C_DEC;
        wrap    = cnt == C_LAST;
        fe_now  = ferr | ~maj;
        done    = 1'b0;
        state_n = state;
        case (state)
            ARM:     if (rx_s && cnt == C_LAST) state_n = IDLE;
            IDLE:    if (!rx_s && rx_d) state_n = START;
            START:   if (dec) state_n = maj ? IDLE : DATA;
            DATA:    if (dec && bcnt == B_DATA) state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY:  if (dec) state_n = STOP;
            STOP: begin
                if (dec && bcnt == B_LAST) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ARM;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m         <= 1'b1;
            rx_s         <= 1'b1;
            rx_d         <= 1'b1;
            cnt          <= '0;
            bcnt         <= '0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            shreg        <= '0;
            par          <= 1'b0;
            ferr         <= 1'b0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_parity_err <= 1'b0;
            m_frame_err  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
            // ARM counts consecutive high samples; IDLE preloads 1 so the start edge is bit time 0
            cnt  <= (state == ARM) ? (rx_s ? cnt + 1'b1 : '0) :
                    (state == IDLE) ? C_ONE : (wrap ? '0 : cnt + 1'b1);
            bcnt <= (state == ARM || state == IDLE) ? '0 : bcnt + BW'(wrap);
            if (cnt == C_SMP0) s0 <= rx_s;
            if (cnt == C_MID) s1 <= rx_s;
            if (state == DATA && dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
            par  <= (state == IDLE) ? 1'b0 :
                    ((state == DATA || state == PARITY) && dec) ? par ^ maj : par;
            ferr <= (state == IDLE) ? 1'b0 : (state == STOP && dec) ? fe_now : ferr;
            overrun <= done && m_valid && !m_ready;
            if (done && (!m_valid || m_ready)) begin
                m_data       <= shreg;
                m_valid      <= 1'b1;
                m_parity_err <= (PARITY_MODE == 0) ? 1'b0 : (PARITY_MODE == 1) ? par : ~par;
                m_frame_err  <= fe_now;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/uart_rx_multi.md
Name: uart_rx_multi

Overview:
- Parametrised UART receiver; next generation of the single-format 8-bit even/odd-parity receiver in the FPGA link path (one receiver per module cable, 6 Mbaud at 48 MHz).
- Adds configurable data width, none/even/odd parity, 1 or 2 stop bits, input synchroniser, 3-sample majority voting and start-glitch rejection.
- Adds a line-idle arming phase, framing-error detection and a valid/ready output holding register with overrun reporting.
- Feeds the ECC decoder / trigger logic downstream.

Parameters:
- CLKS_PER_BIT, 8: clk cycles per bit (48 MHz / 6 Mbaud). Must be at least 4.
- DATA_BITS, 8: payload width, 5..16, sent LSB first.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- rx, input, 1: asynchronous serial line, idle high.
- m_data, output, DATA_BITS: received payload.
- m_valid, output, 1: m_data and the error flags are valid.
- m_ready, input, 1: consumer accepts the word.
- m_parity_err, output, 1: parity mismatch for the held word; 0 when PARITY_MODE=0.
- m_frame_err, output, 1: a stop bit was sampled low for the held word.
- overrun, output, 1: one-cycle pulse when a completed frame is dropped.
- busy, output, 1: high in START, DATA, PARITY and STOP.

Behaviour:
- **Interface:** clock is clk. reset is synchronous and active-high. Reset outputs: m_data=0, m_valid=0, m_parity_err=0, m_frame_err=0, overrun=0, busy=0. Reset forces state ARM, clears the bit counter and holding register, and discards any frame in progress.
- **Synchroniser:** rx passes through a 2-flop synchroniser (rx_s) before all use; both flops reset to 1. This adds 2 cycles of latency.
- **ARM:**
  - rx_s must be high for CLKS_PER_BIT consecutive cycles; then go to IDLE.
  - Any low sample restarts the count.
  - A line held low after reset never starts a frame.
- **IDLE:** on the first cycle rx_s==0 (call it t0), go to START with the clock counter aligned so bit k centre = t0 + k*CLKS_PER_BIT + CLKS_PER_BIT/2 (integer division). Bit 0 is the start bit.
- **Sampling:**
  - Each bit is sampled at centre-1, centre and centre+1; the bit value is the 2-of-3 majority.
  - The decision is taken at centre+1.
- **START:** if the majority is 1, treat it as a glitch and return to IDLE with nothing output. Otherwise go to DATA.
- **DATA:**
  - Shift DATA_BITS bits into the shift register LSB first.
  - Then go to PARITY if PARITY_MODE!=0, else to STOP.
- **PARITY:**
  - Even mode: error = XOR(data bits, parity bit).
  - Odd mode: error = inverse of that XOR.
- **STOP:**
  - Sample STOP_BITS bits; frame_err = 1 if any stop bit majority is 0.
  - After the last stop decision, go to IDLE immediately, with no wait for a full stop bit, so the receiver resynchronises on the next start edge.
  - A frame error still delivers the word (flag set). The receiver does not re-arm, but IDLE cannot retrigger until rx_s returns high then falls.
- **Latency:** m_valid rises at last-stop-centre + 2 relative to t0. For defaults with PARITY_MODE=0 and STOP_BITS=1 this is t0+78. With even parity it is t0+86.
- **Handshake:**
  - A word transfers on a cycle with m_valid && m_ready; m_valid drops the next cycle unless a new word loads that same cycle.
  - m_data and the flags are stable while m_valid && !m_ready.
- **Load and overrun:**
  - A completed frame loads the holding register if m_valid==0, or if m_ready==1 in the completion cycle (simultaneous accept-and-load; no bubble).
  - Otherwise the new frame is dropped, the held word is kept, and overrun pulses for 1 cycle.
- **Reset mid-frame:** the partial frame is lost. No overrun, no valid.
- **Counters:** the clock counter is $clog2(2*CLKS_PER_BIT) bits wide. The bit counter is sized for 1+DATA_BITS+1+2.

Test Plan:
- **Clean frame:** defaults; after reset hold rx=1 for 8 cycles, send 0xA5 with parity 0 and 1 stop, m_ready=1 -> m_valid pulses 1 cycle at t0+86 with m_data=0xA5 and both error flags 0.
- **Parity error:** send 0xA5 with parity bit 1 -> m_data=0xA5, m_parity_err=1. With PARITY_MODE=2 and parity 1 -> m_parity_err=0.
- **Glitch and framing:** rx low for 2 cycles only -> no m_valid, busy returns to 0 by t0+6. Frame 0x3C with stop bit 0 -> m_data=0x3C, m_frame_err=1.
- **Backpressure:** m_ready=0, send 0x11 then 0x22 -> m_data holds 0x11, overrun pulses once at the 0x22 completion. Then set m_ready=1 -> 0x11 transfers and no 0x22 follows.
- **Simultaneous accept-and-load:** m_ready asserted in the exact completion cycle of 0x22 with 0x11 held -> 0x11 accepted, 0x22 loaded the next cycle, no overrun.
- **Reset/arming:** reset with rx held 0 -> no frame until rx has been high 8 cycles. Reset asserted mid-frame -> all outputs 0, no word delivered. Sweep DATA_BITS=5/16 and STOP_BITS=2 for width and latency checks.
